// File: rtl/bht_controller_if.sv
// Lookup, update and table-memory signals of the BHT controller in one bundle.
// slave = controller side; master = requesters plus the table memory.
interface bht_controller_if #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
);
    logic               lk_valid;
    logic [INDEX_W-1:0] lk_index;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_ready;
    logic               lk_resp_valid;
    logic               lk_hit;
    logic [1:0]         lk_counter;
    logic               lk_prediction;

    logic               up_valid;
    logic [INDEX_W-1:0] up_index;
    logic [TAG_W-1:0]   up_tag;
    logic               up_taken;
    logic               up_ready;
    logic               up_done;

    logic [INDEX_W-1:0] mem_addr;
    logic               mem_rd;
    logic               mem_we;
    logic [TAG_W+2:0]   mem_wdata;
    logic [TAG_W+2:0]   mem_rdata;

    modport master (
        output lk_valid, lk_index, lk_tag,
        input  lk_ready, lk_resp_valid, lk_hit, lk_counter, lk_prediction,
        output up_valid, up_index, up_tag, up_taken,
        input  up_ready, up_done,
        input  mem_addr, mem_rd, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        output lk_ready, lk_resp_valid, lk_hit, lk_counter, lk_prediction,
        input  up_valid, up_index, up_tag, up_taken,
        output up_ready, up_done,
        output mem_addr, mem_rd, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/bht_controller.sv
// BHT sequencer: arbitrates lookups/updates onto a single-port table, updates by read-modify-write.
// Latency: lookup result 3 cycles after accept, update done 4 cycles after accept.
// Backpressure: one request in flight; ready only in IDLE. Optional BHT_INIT_CLEAR_EN clears table after reset.
module bht_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    bht_controller_if.slave   bus
);
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
    } entry_t;

`ifdef BHT_INIT_CLEAR_EN
    typedef enum logic [2:0] {INIT, IDLE, RD, CMP, WR} state_t;
    logic [INDEX_W:0] init_cnt;
`else
    typedef enum logic [2:0] {IDLE, RD, CMP, WR} state_t;
`endif

    state_t             state;
    logic               last_up;
    logic               op_up;
    logic [TAG_W-1:0]   tag_q;
    logic               taken_q;

    logic               lk_resp_valid_q;
    logic               lk_hit_q;
    logic [1:0]         lk_counter_q;
    logic               lk_prediction_q;
    logic               up_done_q;
    logic [INDEX_W-1:0] mem_addr_q;
    logic               mem_rd_q;
    logic               mem_we_q;
    entry_t             mem_wdata_q;

    logic   in_idle;
    logic   lk_acc;
    logic   up_acc;
    entry_t rd_e;
    logic   rd_hit;
    logic [1:0] next_ctr;

    // The class not served last wins a tie; a lone request always wins.
    assign in_idle      = (state == IDLE) && !reset;
    assign bus.lk_ready = in_idle && (!bus.up_valid || last_up);
    assign bus.up_ready = in_idle && (!bus.lk_valid || !last_up);
    assign lk_acc       = bus.lk_valid && bus.lk_ready;
    assign up_acc       = bus.up_valid && bus.up_ready;

    assign rd_e   = bus.mem_rdata;
    assign rd_hit = rd_e.valid && (rd_e.tag == tag_q);

    always_comb begin
        next_ctr = rd_e.ctr;
        if (!rd_hit)
            next_ctr = taken_q ? 2'b10 : 2'b01;
        else if (taken_q && rd_e.ctr != 2'b11)
            next_ctr = rd_e.ctr + 2'b01;
        else if (!taken_q && rd_e.ctr != 2'b00)
            next_ctr = rd_e.ctr - 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef BHT_INIT_CLEAR_EN
            state    <= INIT;
            init_cnt <= '0;
`else
            state    <= IDLE;
`endif
            last_up         <= 1'b0;
            op_up           <= 1'b0;
            tag_q           <= '0;
            taken_q         <= 1'b0;
            lk_resp_valid_q <= 1'b0;
            lk_hit_q        <= 1'b0;
            lk_counter_q    <= 2'b00;
            lk_prediction_q <= 1'b0;
            up_done_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_rd_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
        end else begin
            lk_resp_valid_q <= 1'b0;
            up_done_q       <= 1'b0;
            mem_rd_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            case (state)
`ifdef BHT_INIT_CLEAR_EN
                INIT: begin
                    if (!init_cnt[INDEX_W]) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= init_cnt[INDEX_W-1:0];
                        mem_wdata_q <= '0;
                        init_cnt    <= init_cnt + 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                IDLE: begin
                    if (lk_acc || up_acc) begin
                        op_up      <= up_acc;
                        last_up    <= up_acc;
                        tag_q      <= up_acc ? bus.up_tag : bus.lk_tag;
                        taken_q    <= bus.up_taken;
                        mem_addr_q <= up_acc ? bus.up_index : bus.lk_index;
                        mem_rd_q   <= 1'b1;
                        state      <= RD;
                    end
                end
                RD: state <= CMP;
                CMP: begin
                    if (op_up) begin
                        mem_wdata_q <= '{valid: 1'b1, tag: tag_q, ctr: next_ctr};
                        mem_we_q    <= 1'b1;
                        state       <= WR;
                    end else begin
                        lk_hit_q        <= rd_hit;
                        lk_counter_q    <= rd_hit ? rd_e.ctr : 2'b00;
                        lk_prediction_q <= rd_hit && rd_e.ctr[1];
                        lk_resp_valid_q <= 1'b1;
                        state           <= IDLE;
                    end
                end
                WR: begin
                    up_done_q <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.lk_resp_valid = lk_resp_valid_q;
    assign bus.lk_hit        = lk_hit_q;
    assign bus.lk_counter    = lk_counter_q;
    assign bus.lk_prediction = lk_prediction_q;
    assign bus.up_done       = up_done_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule
